// File: rtl/temporizador_pkg.sv
// rtl/temporizador_pkg.sv - shared constants for the phase-strobe timer
// Purpose: FSM state encoding and the default timer geometry reused by the
// vending-machine top level.
package temporizador_pkg;

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] CONTANDO = 2'd1;
    localparam logic [1:0] PAUSADO  = 2'd2;

    localparam int NUM_FASES_PADRAO     = 3;
    localparam int PRIMEIRA_FASE_PADRAO = 2;
    localparam int PERIODO_PADRAO       = 5;
    localparam int LARG_CICLOS_PADRAO   = 8;

endpackage

// File: rtl/temporizador_fases_contador_modulo.sv
// rtl/temporizador_fases_contador_modulo.sv - modulo-PERIODO counter with clear and wrap flag
// Purpose: counts 0..PERIODO-1 while en is high; limpar has priority and
// forces 0 at the next edge.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance the count this edge
//   limpar   : synchronous clear (overrides en)
//   valor_d  : next count value (what the register takes at the next edge)
//   wrap     : current count is PERIODO-1
module contador_modulo #(
    parameter int PERIODO = 5,
    parameter int W       = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         limpar,
    output logic [W-1:0] valor_d,
    output logic         wrap
);

    logic [W-1:0] valor_q;

    always_comb begin
        wrap    = (valor_q == W'(PERIODO - 1));
        valor_d = valor_q;
        if (limpar) begin
            valor_d = '0;
        end else if (en) begin
            valor_d = wrap ? '0 : valor_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

endmodule

// File: rtl/temporizador_fases.sv
// rtl/temporizador_fases.sv - parametrised phase-strobe timer with pause and single-sweep mode
// Purpose: while enabled, runs a modulo-PERIODO count and drives one
// active-low strobe per phase slot, plus an end-of-period pulse and a
// saturating completed-period counter.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   habilitar  : run enable, 0 aborts to idle
//   modo_unico : 1 = one sweep per disparo, 0 = continuous
//   disparo    : start request (single mode, idle only)
//   pausar     : freeze the count while high
//   fase_n     : active-low strobes, bit k at count PRIMEIRA_FASE+k
//   fim_ciclo  : high in the last count slot
//   ocupado    : high while counting or paused
//   ciclos     : completed periods, saturating
module temporizador_fases
    import temporizador_pkg::*;
#(
    parameter int NUM_FASES     = NUM_FASES_PADRAO,
    parameter int PRIMEIRA_FASE = PRIMEIRA_FASE_PADRAO,
    parameter int PERIODO       = PERIODO_PADRAO,
    parameter int LARG_CICLOS   = LARG_CICLOS_PADRAO
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   habilitar,
    input  logic                   modo_unico,
    input  logic                   disparo,
    input  logic                   pausar,
    output logic [NUM_FASES-1:0]   fase_n,
    output logic                   fim_ciclo,
    output logic                   ocupado,
    output logic [LARG_CICLOS-1:0] ciclos
);

    localparam int LARG_CONT = (PERIODO > 1) ? $clog2(PERIODO) : 1;

    if ((NUM_FASES < 1) || (PERIODO < PRIMEIRA_FASE + NUM_FASES)) begin : g_param_invalido
        $error("temporizador_fases: PERIODO must be >= PRIMEIRA_FASE+NUM_FASES and NUM_FASES >= 1");
    end

    logic [1:0]             estado_q, estado_d;
    logic [LARG_CICLOS-1:0] ciclos_q, ciclos_d;
    logic [NUM_FASES-1:0]   fase_n_q, fase_n_d;
    logic                   fim_ciclo_q, fim_ciclo_d;
    logic                   ocupado_q, ocupado_d;

    logic                   cont_en, cont_limpar, cont_wrap;
    logic [LARG_CONT-1:0]   contador_d;

    contador_modulo #(
        .PERIODO (PERIODO),
        .W       (LARG_CONT)
    ) u_contador (
        .clk     (clk),
        .rst     (rst),
        .en      (cont_en),
        .limpar  (cont_limpar),
        .valor_d (contador_d),
        .wrap    (cont_wrap)
    );

    always_comb begin
        estado_d    = estado_q;
        ciclos_d    = ciclos_q;
        cont_en     = 1'b0;
        cont_limpar = 1'b0;
        case (estado_q)
            CONTANDO: begin
                if (!habilitar) begin
                    estado_d    = OCIOSO;
                    cont_limpar = 1'b1;
                end else if (pausar) begin
                    estado_d = PAUSADO;
                end else begin
                    cont_en = 1'b1;
                    if (cont_wrap) begin
                        if (ciclos_q != '1) begin
                            ciclos_d = ciclos_q + LARG_CICLOS'(1);
                        end
                        // modo_unico is only honoured here, so a mid-period change
                        // takes effect at the next wrap.
                        if (modo_unico) begin
                            estado_d = OCIOSO;
                        end
                    end
                end
            end
            PAUSADO: begin
                if (!habilitar) begin
                    estado_d    = OCIOSO;
                    cont_limpar = 1'b1;
                end else if (!pausar) begin
                    estado_d = CONTANDO;
                end
            end
            default: begin
                cont_limpar = 1'b1;
                if (habilitar && (!modo_unico || disparo)) begin
                    estado_d = CONTANDO;
                    ciclos_d = '0;
                end
            end
        endcase
    end

    // Outputs are decoded from next-state values so the registered outputs
    // line up with the state/count they describe.
    always_comb begin
        fase_n_d    = '1;
        fim_ciclo_d = 1'b0;
        ocupado_d   = (estado_d != OCIOSO);
        if (estado_d == CONTANDO) begin
            for (int k = 0; k < NUM_FASES; k++) begin
                if (contador_d == LARG_CONT'(PRIMEIRA_FASE + k)) begin
                    fase_n_d[k] = 1'b0;
                end
            end
            fim_ciclo_d = (contador_d == LARG_CONT'(PERIODO - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= OCIOSO;
            ciclos_q    <= '0;
            fase_n_q    <= '1;
            fim_ciclo_q <= 1'b0;
            ocupado_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            ciclos_q    <= ciclos_d;
            fase_n_q    <= fase_n_d;
            fim_ciclo_q <= fim_ciclo_d;
            ocupado_q   <= ocupado_d;
        end
    end

    assign fase_n    = fase_n_q;
    assign fim_ciclo = fim_ciclo_q;
    assign ocupado   = ocupado_q;
    assign ciclos    = ciclos_q;

endmodule
